// File: rtl/ikbd_rx_pacer_if.sv
// IKBD byte pacer bus: SPI-side byte strobe in, ACIA-side byte strobe out,
// plus flush/hold controls and buffer status.
interface ikbd_rx_pacer_if #(
    parameter int DEPTH_LOG2 = 3
);
    logic                  in_strobe;
    logic [7:0]            in_data;
    logic                  flush;
    logic                  hold;
    logic                  clear_overflow;
    logic                  out_strobe;
    logic [7:0]            out_data;
    logic [DEPTH_LOG2:0]   level;
    logic                  overflow;

    modport master (
        output in_strobe, in_data, flush, hold, clear_overflow,
        input  out_strobe, out_data, level, overflow
    );

    modport slave (
        input  in_strobe, in_data, flush, hold, clear_overflow,
        output out_strobe, out_data, level, overflow
    );
endinterface

// File: rtl/ikbd_rx_pacer.sv
// Buffers IKBD bytes from the IO controller and releases them to the ACIA
// no faster than one 10-bit serial frame apart.
module ikbd_rx_pacer #(
    parameter int DEPTH_LOG2 = 3,
    parameter int BYTE_CLKS  = 10240
) (
    input logic             clk,
    input logic             reset,
    ikbd_rx_pacer_if.slave  bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = (BYTE_CLKS > 1) ? $clog2(BYTE_CLKS) : 1;

    localparam logic [CW-1:0]         GAP_INIT = CW'(BYTE_CLKS - 1);
    localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
    localparam logic [DEPTH_LOG2:0]   FULL     = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    typedef enum logic {IDLE, GAP} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic [7:0]            out_data_q, out_data_d;
    logic                  out_strobe_q, out_strobe_d;
    logic                  overflow_q, overflow_d;
    logic                  hold_q;
    logic [7:0]            mem_q [DEPTH];

    logic release_go;
    logic pop;
    logic push;
    logic drop;

    // The head leaves the FIFO in the cycle its strobe is visible.
    assign release_go = (state_q == IDLE) && (level_q != '0)
                        && !hold_q && !bus.flush;
    assign pop  = out_strobe_q && !bus.flush;
    assign push = bus.in_strobe && !bus.flush && ((level_q != FULL) || pop);
    assign drop = bus.in_strobe && !bus.flush && (level_q == FULL) && !pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            out_data_q   <= '0;
            out_strobe_q <= 1'b0;
            overflow_q   <= 1'b0;
            hold_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            out_data_q   <= out_data_d;
            out_strobe_q <= out_strobe_d;
            overflow_q   <= overflow_d;
            hold_q       <= bus.hold;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem_q[wr_ptr_q] <= bus.in_data;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (bus.flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (release_go) begin
                        state_d = GAP;
                        cnt_d   = GAP_INIT;
                    end
                end
                GAP: begin
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            endcase
        end
    end

    always_comb begin
        out_strobe_d = release_go;
        out_data_d   = release_go ? mem_q[rd_ptr_q] : out_data_q;
        rd_ptr_d     = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        wr_ptr_d     = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        level_d      = level_q;
        if (push && !pop) begin
            level_d = level_q + LVL_ONE;
        end else if (pop && !push) begin
            level_d = level_q - LVL_ONE;
        end
        // A dropped byte outranks a same-cycle clear.
        if (drop) begin
            overflow_d = 1'b1;
        end else if (bus.clear_overflow) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
        if (bus.flush) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            level_d    = '0;
            overflow_d = 1'b0;
        end
    end

    assign bus.out_strobe = out_strobe_q && !reset;
    assign bus.out_data   = out_data_q;
    assign bus.level      = level_q;
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_ikbd_rx_pacer.sv
// Randomized and directed bench for ikbd_rx_pacer against a
// queue/timestamp reference model.
module tb_ikbd_rx_pacer;
    localparam int DL = 3;
    localparam int D  = 1 << DL;
    localparam int B  = 10240;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ikbd_rx_pacer_if #(.DEPTH_LOG2(DL)) bus ();

    ikbd_rx_pacer #(.DEPTH_LOG2(DL), .BYTE_CLKS(B)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // reference model: bytes waiting, last release time, visible outputs
    logic [7:0] mq [$];
    logic       m_stb  = 1'b0;
    logic [7:0] m_data = 8'h00;
    logic       m_ovf  = 1'b0;
    logic       m_hold = 1'b0;
    bit         rel_valid = 1'b0;
    longint     last_rel  = 0;
    longint     cyc       = 0;

    longint     st_t [$];
    logic [7:0] st_d [$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h",
                     tag, cyc, obs, exp);
        end
    endtask

    task automatic model(input bit r, input bit s, input logic [7:0] d,
                         input bit f, input bit h, input bit c);
        int  lvl;
        bit  popping, nxt, dropped;
        if (r) begin
            mq.delete();
            m_stb = 0; m_data = 8'h00; m_ovf = 0;
            rel_valid = 0; m_hold = 0;
            return;
        end
        if (f) begin
            mq.delete();
            m_stb = 0; m_ovf = 0;
            rel_valid = 0; m_hold = h;
            return;
        end
        lvl     = mq.size();
        popping = m_stb;
        dropped = 0;
        nxt = (lvl != 0) && !m_hold &&
              (!rel_valid || (cyc + 1 - last_rel >= B + 1));
        if (nxt) begin
            m_data    = mq[0];
            last_rel  = cyc + 1;
            rel_valid = 1;
        end
        if (popping) void'(mq.pop_front());
        if (s) begin
            if (lvl < D || popping) mq.push_back(d);
            else dropped = 1;
        end
        if (dropped) m_ovf = 1;
        else if (c) m_ovf = 0;
        m_stb  = nxt;
        m_hold = h;
    endtask

    task automatic step(input bit r, input bit s, input logic [7:0] d,
                        input bit f, input bit h, input bit c);
        @(negedge clk);
        reset = r;
        bus.in_strobe = s; bus.in_data = d;
        bus.flush = f; bus.hold = h; bus.clear_overflow = c;
        #1;
        chk("out_strobe", bus.out_strobe, m_stb && !r);
        chk("out_data", bus.out_data, m_data);
        chk("level", bus.level, mq.size());
        chk("overflow", bus.overflow, m_ovf);
        if (bus.out_strobe === 1'b1) begin
            st_t.push_back(cyc);
            st_d.push_back(bus.out_data);
        end
        model(r, s, d, f, h, c);
        cyc++;
    endtask

    task automatic idle(input int n, input bit h);
        repeat (n) step(0, 0, 8'h00, 0, h, 0);
    endtask

    task automatic clear_log();
        st_t.delete();
        st_d.delete();
    endtask

    initial begin
        longint n;
        bit h;
        reset = 1'b1;
        bus.in_strobe = 0; bus.in_data = 8'h00;
        bus.flush = 0; bus.hold = 0; bus.clear_overflow = 0;
        repeat (2) @(posedge clk);

        step(1, 0, 8'h00, 0, 0, 0);
        idle(5, 0);
        chk("rst_level", bus.level, 0);
        chk("rst_data", bus.out_data, 8'h00);

        // single byte
        clear_log();
        n = cyc;
        step(0, 1, 8'hF6, 0, 0, 0);
        idle(1, 0);
        chk("single_lvl1", bus.level, 1);
        idle(1, 0);
        chk("single_stb", bus.out_strobe, 1);
        chk("single_data", bus.out_data, 8'hF6);
        idle(1, 0);
        chk("single_lvl0", bus.level, 0);
        chk("single_stb_w", bus.out_strobe, 0);
        chk("single_time", 32'(st_t[0] - n), 2);
        step(0, 0, 8'h00, 1, 0, 0);

        // burst pacing
        clear_log();
        step(0, 1, 8'h01, 0, 0, 0);
        step(0, 1, 8'h02, 0, 0, 0);
        step(0, 1, 8'h03, 0, 0, 0);
        idle(2 * (B + 1) + 5, 0);
        chk("burst_cnt", st_t.size(), 3);
        if (st_t.size() == 3) begin
            chk("burst_sp1", 32'(st_t[1] - st_t[0]), B + 1);
            chk("burst_sp2", 32'(st_t[2] - st_t[1]), B + 1);
            chk("burst_d0", st_d[0], 8'h01);
            chk("burst_d1", st_d[1], 8'h02);
        end
        chk("burst_hold", bus.out_data, 8'h03);
        step(0, 0, 8'h00, 1, 0, 0);

        // overflow
        for (int i = 0; i < 10; i++) step(0, 1, 8'(i), 0, 0, 0);
        idle(1, 0);
        chk("ovf_level", bus.level, 8);
        chk("ovf_flag", bus.overflow, 1);
        step(0, 0, 8'h00, 0, 0, 1);
        idle(1, 0);
        chk("ovf_clr", bus.overflow, 0);
        step(0, 0, 8'h00, 1, 0, 0);

        // flush mid-gap
        for (int i = 0; i < 5; i++) step(0, 1, 8'(8'h40 + i), 0, 0, 0);
        idle(20, 0);
        step(0, 0, 8'h00, 1, 0, 0);
        idle(1, 0);
        chk("flush_lvl", bus.level, 0);
        clear_log();
        idle(100, 0);
        chk("flush_quiet", st_t.size(), 0);
        step(0, 1, 8'hA5, 0, 0, 0);
        idle(2, 0);
        chk("flush_stb", bus.out_strobe, 1);
        chk("flush_data", bus.out_data, 8'hA5);
        step(0, 0, 8'h00, 1, 0, 0);

        // hold
        idle(2, 1);
        step(0, 1, 8'h11, 0, 1, 0);
        step(0, 1, 8'h22, 0, 1, 0);
        clear_log();
        idle(20000, 1);
        chk("hold_quiet", st_t.size(), 0);
        chk("hold_lvl", bus.level, 2);
        n = cyc;
        idle(B + 20, 0);
        chk("hold_cnt", st_t.size(), 2);
        if (st_t.size() == 2) begin
            chk("hold_first", 32'(st_t[0] - n), 2);
            chk("hold_sp", 32'(st_t[1] - st_t[0]), B + 1);
            chk("hold_d1", st_d[1], 8'h22);
        end
        step(0, 0, 8'h00, 1, 0, 0);

        // reset mid-burst
        for (int i = 0; i < 5; i++) step(0, 1, 8'(8'h80 + i), 0, 0, 0);
        idle(50, 0);
        step(1, 0, 8'h00, 0, 0, 0);
        chk("rst_mid_stb", bus.out_strobe, 0);
        idle(1, 0);
        chk("rst_mid_lvl", bus.level, 0);
        chk("rst_mid_data", bus.out_data, 8'h00);
        clear_log();
        idle(200, 0);
        chk("rst_mid_quiet", st_t.size(), 0);

        // randomized traffic
        h = 0;
        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(199) == 0) h = ~h;
            step($urandom_range(511) == 0, $urandom_range(2) == 0,
                 8'($urandom), $urandom_range(127) == 0, h,
                 $urandom_range(49) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
